// File: rtl/guess_entry.sv
// -----------------------------------------------------------------------------
// guess_entry
//
// Purpose:
//   Sits behind the PS/2 keyboard decoder. Debounces the level-coded key
//   output, turns each new press into a single accept event, and assembles
//   a 4-peg Mastermind guess from the digit keys. Keys 1..8 select colours
//   0..7; key 0 submits a complete guess to the scoring logic.
//
// Handshake (guess_valid / guess_ack):
//   guess_valid rises once a full guess is submitted and stays high, with
//   guess and peg_count frozen, until an edge samples guess_ack=1. That edge
//   clears the guess and returns to entry. guess_ack is ignored while
//   guess_valid=0.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   resetn      in   1   asynchronous active-low reset
//   kb_code     in   5   decoder code: 01000..01111 keys 1..8, 10000 key 0,
//                        anything else means no key
//   guess_ack   in   1   consumer accepts the pending guess
//   guess       out  12  slot n in bits [3n+2:3n], slot 0 entered first
//   peg_count   out  3   pegs entered so far (0..4)
//   guess_valid out  1   complete guess awaiting acknowledge
//   key_pulse   out  1   one-cycle pulse per accepted press (even if ignored)
//   dbg_state   out  3   {entry_state, detector_state} for observation
// -----------------------------------------------------------------------------
module guess_entry #(
  parameter int STABLE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  kb_code,
  input  logic        guess_ack,
  output logic [11:0] guess,
  output logic [2:0]  peg_count,
  output logic        guess_valid,
  output logic        key_pulse,
  output logic [2:0]  dbg_state
);

  localparam int             CW         = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_STABLE = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  // Key detector states
  localparam logic [1:0] S_WAIT_KEY     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE     = 2'd1;
  localparam logic [1:0] S_WAIT_RELEASE = 2'd2;

  // Entry states
  localparam logic S_ENTRY  = 1'b0;
  localparam logic S_SUBMIT = 1'b1;

  localparam logic [4:0] CODE_ZERO = 5'b10000;

  // Detector state
  logic [1:0]    r_det_state;
  logic [4:0]    r_key;
  logic [CW-1:0] r_cnt;

  // Entry state
  logic          r_entry_state;
  logic [11:0]   r_guess;
  logic [2:0]    r_peg_count;
  logic          r_guess_valid;
  logic          r_key_pulse;

  // Decoded input
  logic          w_kb_colour;
  logic          w_kb_zero;
  logic          w_kb_valid;

  // Detector next-state
  logic [1:0]    w_det_next;
  logic [4:0]    w_key_next;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_accept;

  assign w_kb_colour = (kb_code[4:3] == 2'b01);
  assign w_kb_zero   = (kb_code == CODE_ZERO);
  assign w_kb_valid  = w_kb_colour | w_kb_zero;
  assign w_cnt_inc   = r_cnt + CNT_ONE;

  // ---------------------------------------------------------------------------
  // Key detector. w_accept is asserted combinationally on the edge where the
  // press becomes stable; the accepted code is always the current kb_code
  // because an accept only happens while kb_code matches the latched key.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_det_next = r_det_state;
    w_key_next = r_key;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_det_state)
      S_WAIT_KEY: begin
        if (w_kb_valid) begin
          w_key_next = kb_code;
          if (STABLE_CYCLES == 1) begin
            w_accept   = 1'b1;
            w_det_next = S_WAIT_RELEASE;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = CNT_ONE;
            w_det_next = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (!w_kb_valid) begin
          w_det_next = S_WAIT_KEY;
          w_cnt_next = '0;
        end else if (kb_code == r_key) begin
          if (w_cnt_inc == CNT_STABLE) begin
            w_accept   = 1'b1;
            w_det_next = S_WAIT_RELEASE;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end else begin
          // A different key restarts debouncing on the new code.
          w_key_next = kb_code;
          w_cnt_next = CNT_ONE;
        end
      end
      S_WAIT_RELEASE: begin
        // Only an unbroken run of no-key samples re-arms the detector, so a
        // held key can never produce a second accept.
        if (w_kb_valid) begin
          w_cnt_next = '0;
        end else if (w_cnt_inc == CNT_STABLE) begin
          w_det_next = S_WAIT_KEY;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_det_next = S_WAIT_KEY;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_det_state <= S_WAIT_KEY;
      r_key       <= 5'd0;
      r_cnt       <= '0;
    end else begin
      r_det_state <= w_det_next;
      r_key       <= w_key_next;
      r_cnt       <= w_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FSM. Acts on the accept in the same edge, so key_pulse, guess and
  // peg_count all show the result in the cycle following the accept edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_entry_state <= S_ENTRY;
      r_guess       <= 12'd0;
      r_peg_count   <= 3'd0;
      r_guess_valid <= 1'b0;
      r_key_pulse   <= 1'b0;
    end else begin
      r_key_pulse <= w_accept;
      case (r_entry_state)
        S_ENTRY: begin
          if (w_accept) begin
            if (w_kb_zero) begin
              if (r_peg_count == 3'd4) begin
                r_guess_valid <= 1'b1;
                r_entry_state <= S_SUBMIT;
              end
            end else if (r_peg_count != 3'd4) begin
              case (r_peg_count)
                3'd0:    r_guess[2:0]  <= kb_code[2:0];
                3'd1:    r_guess[5:3]  <= kb_code[2:0];
                3'd2:    r_guess[8:6]  <= kb_code[2:0];
                default: r_guess[11:9] <= kb_code[2:0];
              endcase
              r_peg_count <= r_peg_count + 3'd1;
            end
          end
        end
        S_SUBMIT: begin
          // Acknowledge wins over any accept on the same edge.
          if (guess_ack) begin
            r_guess_valid <= 1'b0;
            r_guess       <= 12'd0;
            r_peg_count   <= 3'd0;
            r_entry_state <= S_ENTRY;
          end
        end
        default: r_entry_state <= S_ENTRY;
      endcase
    end
  end

  assign guess       = r_guess;
  assign peg_count   = r_peg_count;
  assign guess_valid = r_guess_valid;
  assign key_pulse   = r_key_pulse;
  assign dbg_state   = {r_entry_state, r_det_state};

endmodule

// File: tb/tb_guess_entry.sv
// -----------------------------------------------------------------------------
// tb_guess_entry
//
// Directed stimulus with hand-computed expectations for STABLE_CYCLES=4.
// Each expected accept is queued as {edge number, guess, peg_count,
// guess_valid}; a monitor pops an entry for every key_pulse and compares.
// Inputs change on the falling edge; outputs are observed 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_guess_entry;

  logic        clk;
  logic        resetn;
  logic [4:0]  kb_code;
  logic        guess_ack;
  logic [11:0] guess;
  logic [2:0]  peg_count;
  logic        guess_valid;
  logic        key_pulse;
  logic [2:0]  dbg_state;

  logic [47:0] exp_q[$];
  int          edge_cnt = 0;
  int          n_vec    = 0;
  int          n_err    = 0;

  guess_entry #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .kb_code     (kb_code),
    .guess_ack   (guess_ack),
    .guess       (guess),
    .peg_count   (peg_count),
    .guess_valid (guess_valid),
    .key_pulse   (key_pulse),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic check_state(input string name, input logic [11:0] g, input logic [2:0] p,
                             input logic v);
    check({name, "_guess"}, 32'(guess), 32'(g));
    check({name, "_peg"},   32'(peg_count), 32'(p));
    check({name, "_valid"}, 32'(guess_valid), 32'(v));
  endtask

  // Drivers: called on a falling edge, return on a falling edge.
  task automatic hold(input logic [4:0] code, input int n);
    kb_code = code;
    repeat (n) @(negedge clk);
  endtask

  // Clean press: 4 stable edges then 4 release edges; accept on the 4th edge.
  task automatic press(input logic [4:0] code, input logic [11:0] g, input logic [2:0] p,
                       input logic v);
    exp_q.push_back({32'(edge_cnt + 4), g, p, v});
    hold(code, 4);
    hold(5'b00000, 4);
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    logic [47:0] e;
    edge_cnt = edge_cnt + 1;
    #1;
    if (key_pulse === 1'b1) begin
      check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_edge",  32'(edge_cnt), e[47:16]);
        check("pulse_guess", 32'(guess), 32'(e[15:4]));
        check("pulse_peg",   32'(peg_count), 32'(e[3:1]));
        check("pulse_valid", 32'(guess_valid), 32'(e[0]));
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    kb_code   = 5'b00000;
    guess_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset", 12'd0, 3'd0, 1'b0);
    check("reset_pulse", 32'(key_pulse), 32'd0);
    check("reset_dbg", 32'(dbg_state), 32'd0);
    resetn = 1'b1;
    hold(5'b00000, 2);

    // Key 3 -> colour 2 in slot 0
    press(5'b01010, 12'h002, 3'd1, 1'b0);
    check("t1_slot0", 32'(guess[2:0]), 32'd2);

    // Short press (3 edges) is dropped; bounce 01000 then 01001 stores colour 1
    hold(5'b01000, 3);
    hold(5'b00000, 1);
    check("t2_short_peg", 32'(peg_count), 32'd1);
    exp_q.push_back({32'(edge_cnt + 6), 12'h00A, 3'd2, 1'b0});
    hold(5'b01000, 2);
    hold(5'b01001, 4);
    hold(5'b00000, 4);

    // Long hold of key 8 -> one accept; re-press without full release ignored
    exp_q.push_back({32'(edge_cnt + 4), 12'h1CA, 3'd3, 1'b0});
    hold(5'b01111, 20);
    hold(5'b00000, 2);
    hold(5'b01111, 6);
    hold(5'b00000, 4);
    check_state("t3_after", 12'h1CA, 3'd3, 1'b0);
    check("t3_pending", 32'(exp_q.size()), 32'd0);

    // Fresh start: enter 1,2,3,4, then 5 (ignored), 0 (submit), 6 (ignored)
    resetn = 1'b0;
    @(negedge clk);
    check_state("t4_reset", 12'd0, 3'd0, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    press(5'b01000, 12'h000, 3'd1, 1'b0);
    press(5'b01001, 12'h008, 3'd2, 1'b0);
    press(5'b01010, 12'h088, 3'd3, 1'b0);
    press(5'b01011, 12'h688, 3'd4, 1'b0);
    press(5'b01100, 12'h688, 3'd4, 1'b0);
    press(5'b10000, 12'h688, 3'd4, 1'b1);
    press(5'b01101, 12'h688, 3'd4, 1'b1);

    // Guess held without ack, then cleared by a one-cycle ack
    hold(5'b00000, 10);
    check_state("t5_held", 12'h688, 3'd4, 1'b1);
    guess_ack = 1'b1;
    @(negedge clk);
    guess_ack = 1'b0;
    check_state("t5_acked", 12'h000, 3'd0, 1'b0);

    // Accept on the same edge as ack is ignored
    press(5'b01000, 12'h000, 3'd1, 1'b0);
    press(5'b01001, 12'h008, 3'd2, 1'b0);
    press(5'b01010, 12'h088, 3'd3, 1'b0);
    press(5'b01011, 12'h688, 3'd4, 1'b0);
    press(5'b10000, 12'h688, 3'd4, 1'b1);
    exp_q.push_back({32'(edge_cnt + 4), 12'h000, 3'd0, 1'b0});
    hold(5'b01110, 3);
    guess_ack = 1'b1;
    @(negedge clk);
    guess_ack = 1'b0;
    hold(5'b00000, 4);
    check_state("t6_after", 12'h000, 3'd0, 1'b0);

    // Submit with only 2 pegs is ignored; stray ack does nothing
    press(5'b01000, 12'h000, 3'd1, 1'b0);
    press(5'b01001, 12'h008, 3'd2, 1'b0);
    press(5'b10000, 12'h008, 3'd2, 1'b0);
    guess_ack = 1'b1;
    @(negedge clk);
    guess_ack = 1'b0;
    check_state("t7_stray_ack", 12'h008, 3'd2, 1'b0);

    // Reset mid-debounce clears immediately and no accept follows
    hold(5'b01000, 2);
    resetn = 1'b0;
    #1;
    check_state("t8_async", 12'h000, 3'd0, 1'b0);
    check("t8_dbg", 32'(dbg_state), 32'd0);
    @(negedge clk);
    kb_code = 5'b00000;
    @(negedge clk);
    resetn = 1'b1;
    hold(5'b00000, 10);
    check("t8_peg", 32'(peg_count), 32'd0);
    press(5'b01011, 12'h003, 3'd1, 1'b0);

    check("pending_pulses", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
